mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares one 16-word x 4-bit data memory between two requesters
// (A and B). Each access takes three cycles (grant, access, acknowledge),
// and the two requesters are served round-robin when they contend.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high reset
//   a_req        A access request (level, held until a_ack)
//   a_we         A direction: 1 = write, 0 = read
//   a_addr[3:0]  A word address
//   a_wdata[3:0] A write data
//   a_ack        A one-cycle completion pulse
//   a_rdata[3:0] A registered read result
//   b_*          requester B, same meaning as the A ports
//   mem_read     memory read enable
//   mem_write    memory write enable (memory commits on the rising edge)
//   mem_address  memory word address
//   mem_wdata    memory write data
//   mem_rdata    memory combinational read data
// ---------------------------------------------------------------------------
module mem_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [3:0] a_addr,
  input  logic [3:0] a_wdata,
  output logic       a_ack,
  output logic [3:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [3:0] b_addr,
  input  logic [3:0] b_wdata,
  output logic       b_ack,
  output logic [3:0] b_rdata,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_address,
  output logic [3:0] mem_wdata,
  input  logic [3:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } ArbState;

  ArbState    r_state;
  ArbState    w_nextState;

  // Requester encoding used by r_lastGrant and r_winner: 0 = A, 1 = B.
  logic       r_lastGrant;
  logic       r_winner;
  logic       r_we;
  logic [3:0] r_addr;
  logic [3:0] r_wdata;
  logic [3:0] r_aRdata;
  logic [3:0] r_bRdata;

  logic       w_anyReq;
  logic       w_grantB;

  // B wins when it asks alone, or when both ask and A was the last one served.
  assign w_anyReq = a_req | b_req;
  assign w_grantB = b_req & (~a_req | ~r_lastGrant);

  // State register: the whole handshake timing hangs off this register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a grant always runs exactly one ACCESS cycle and one
  // ACK cycle before the arbiter looks at the request lines again.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = ACCESS;
      ACCESS:  w_nextState = ACK;
      ACK:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Grant latch: the winner's command is captured only at the IDLE edge, so
  // requesters may change their inputs freely once they have seen their ack.
  // last_grant resets to B so that A wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant <= 1'b1;
      r_winner    <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 4'd0;
      r_wdata     <= 4'd0;
    end else if ((r_state == IDLE) && w_anyReq) begin
      r_lastGrant <= w_grantB;
      r_winner    <= w_grantB;
      r_we        <= w_grantB ? b_we    : a_we;
      r_addr      <= w_grantB ? b_addr  : a_addr;
      r_wdata     <= w_grantB ? b_wdata : a_wdata;
    end
  end

  // Read capture: memory data is sampled at the edge that closes ACCESS and
  // only the winner's result register is touched; writes leave both alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aRdata <= 4'd0;
      r_bRdata <= 4'd0;
    end else if ((r_state == ACCESS) && !r_we) begin
      if (r_winner) begin
        r_bRdata <= mem_rdata;
      end else begin
        r_aRdata <= mem_rdata;
      end
    end
  end

  // Memory strobes are gated by reset directly so that a reset landing in
  // the middle of ACCESS can never commit a write.
  assign mem_read    = (r_state == ACCESS) & ~r_we & ~reset;
  assign mem_write   = (r_state == ACCESS) &  r_we & ~reset;
  assign mem_address = r_addr;
  assign mem_wdata   = r_wdata;

  assign a_ack   = (r_state == ACK) & ~r_winner;
  assign b_ack   = (r_state == ACK) &  r_winner;
  assign a_rdata = r_aRdata;
  assign b_rdata = r_bRdata;

endmodule
